window_feeder: RTL

WINDOW_FEEDER -- requirements
Module: window_feeder

---
 rtl/window_feeder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - streams fmap columns into the conv ALU and tags each complete window
// Columns are read once per output row; each load shifts k row bits into the ALU.
module window_feeder #(
   parameter int MAX_H = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       kernel_size,
   input  logic [5:0]       fmap_w,
   input  logic [5:0]       fmap_h,
   input  logic [24:0]      weight_in,
   input  logic             hold,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr,
   input  logic [MAX_H-1:0] rd_data,
   output logic             ifmaps_row0_out,
   output logic             ifmaps_row1_out,
   output logic             ifmaps_row2_out,
   output logic             ifmaps_row3_out,
   output logic             ifmaps_row4_out,
   output logic             load_ifmaps,
   output logic [24:0]      weight_out,
   output logic             load_weight,
   output logic             operation,
   output logic             win_valid,
   output logic [4:0]       win_row,
   output logic [4:0]       win_col,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_LOADW, S_FEED, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [5:0]  w_q, w_d, h_q, h_d;
   logic [24:0] wt_q, wt_d;
   logic [5:0]  r_q, r_d, c_q, c_d;
   logic        v1_q, v1_d, v2_q, v2_d;
   logic [4:0]  r1_q, r1_d, r2_q, r2_d;
   logic [5:0]  c1_q, c1_d, c2_q, c2_d;
   logic [4:0]  rows_q, rows_d;
   logic        wv_q, wv_d;
   logic [4:0]  wr_q, wr_d, wc_q, wc_d;
   logic        err_q, err_d, done_q, done_d;

   logic [2:0]  start_k;
   logic        start_bad;
   logic [4:0]  kmask;
   logic        last_col, last_row;

   function automatic logic [2:0] k_of(input logic [4:0] ks);
      k_of = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (ks[i]) k_of = 3'(i + 1);
      end
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q    <= '0;
         w_q    <= '0;
         h_q    <= '0;
         wt_q   <= '1;
         r_q    <= '0;
         c_q    <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         r1_q   <= '0;
         r2_q   <= '0;
         c1_q   <= '0;
         c2_q   <= '0;
         rows_q <= '0;
         wv_q   <= 1'b0;
         wr_q   <= '0;
         wc_q   <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         k_q    <= k_d;
         w_q    <= w_d;
         h_q    <= h_d;
         wt_q   <= wt_d;
         r_q    <= r_d;
         c_q    <= c_d;
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         r1_q   <= r1_d;
         r2_q   <= r2_d;
         c1_q   <= c1_d;
         c2_q   <= c2_d;
         rows_q <= rows_d;
         wv_q   <= wv_d;
         wr_q   <= wr_d;
         wc_q   <= wc_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   assign start_k   = k_of(kernel_size);
   assign start_bad = (start_k == 3'd0) || (fmap_w == 6'd0) || (fmap_h == 6'd0) ||
                      ({3'b0, start_k} > fmap_w) || ({3'b0, start_k} > fmap_h) ||
                      (int'(fmap_w) > (1 << AW)) || (int'(fmap_h) > MAX_H);
   assign last_col  = (c_q == w_q - 6'd1);
   assign last_row  = (r_q == h_q - {3'b0, k_q});

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      w_d     = w_q;
      h_d     = h_q;
      wt_d    = wt_q;
      r_d     = r_q;
      c_d     = c_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_bad) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = S_LOADW;
                  k_d     = start_k;
                  w_d     = fmap_w;
                  h_d     = fmap_h;
                  wt_d    = weight_in;
                  r_d     = '0;
                  c_d     = '0;
               end
            end
         end
         S_LOADW: state_d = S_FEED;
         S_FEED: begin
            if (!hold) begin
               if (last_col) begin
                  c_d = '0;
                  if (last_row) state_d = S_DRAIN;
                  else          r_d = r_q + 6'd1;
               end else begin
                  c_d = c_q + 6'd1;
               end
            end
         end
         S_DRAIN: begin
            // The window stage runs one cycle behind v2, so done lands after the last window.
            if (!v1_q && !v2_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en       = (state_q == S_FEED) && !hold;
      load_weight = (state_q == S_LOADW);
      busy        = (state_q != S_IDLE);
   end

   // Read -> data capture -> ALU load -> window tag, each one register apart.
   assign kmask = 5'((6'd1 << k_q) - 6'd1);

   always_comb begin
      v1_d   = rd_en;
      r1_d   = r_q[4:0];
      c1_d   = c_q;
      v2_d   = v1_q;
      r2_d   = r1_q;
      c2_d   = c1_q;
      rows_d = v1_q ? (5'(rd_data >> r1_q) & kmask) : 5'd0;
      wv_d   = v2_q && ((c2_q + 6'd1) >= {3'b0, k_q});
      wr_d   = wv_d ? r2_q : 5'd0;
      wc_d   = wv_d ? 5'(c2_q + 6'd1 - {3'b0, k_q}) : 5'd0;
   end

   assign rd_addr         = c_q[AW-1:0];
   assign ifmaps_row0_out = rows_q[0];
   assign ifmaps_row1_out = rows_q[1];
   assign ifmaps_row2_out = rows_q[2];
   assign ifmaps_row3_out = rows_q[3];
   assign ifmaps_row4_out = rows_q[4];
   assign load_ifmaps     = v2_q;
   assign weight_out      = wt_q;
   assign operation       = 1'b0;
   assign win_valid       = wv_q;
   assign win_row         = wr_q;
   assign win_col         = wc_q;
   assign done            = done_q;
   assign err             = err_q;

endmodule
